watch_gen2: RTL and testbench

WATCH_GEN2 -- requirements
Module: watch_gen2

---
 rtl/watch_pkg.sv | 34 +++
 rtl/watch_gen2_tick_gen.sv | 31 +++
 rtl/watch_gen2.sv | 143 ++++++++++++++
 tb/tb_watch_gen2.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types, field limits and the wrapping field-step helper for the watch.
package watch_pkg;

  // The state encoding is also the edit_field output value.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_SEC  = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_HOUR = 2'd3
  } state_e;

  localparam logic [1:0] EF_RUN  = 2'd0;
  localparam logic [1:0] EF_SEC  = 2'd1;
  localparam logic [1:0] EF_MIN  = 2'd2;
  localparam logic [1:0] EF_HOUR = 2'd3;

  localparam logic [5:0] SEC_LIM  = 6'd60;
  localparam logic [5:0] MIN_LIM  = 6'd60;
  localparam logic [5:0] HOUR_LIM = 6'd24;

  // One edit step on a field, wrapping inside 0..lim-1; out-of-range values snap back in.
  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] lim,
                                            input logic up, input logic dn);
    logic [5:0] r;
    r = (v >= lim) ? 6'd0 : v;
    if (up && !dn) begin
      r = (v >= lim - 6'd1) ? 6'd0 : v + 6'd1;
    end else if (dn && !up) begin
      r = (v == 6'd0 || v >= lim) ? lim - 6'd1 : v - 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/watch_gen2_tick_gen.sv
// Clock divider: one-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
// Counter is held at zero while disabled or cleared.
module tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || !en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/watch_gen2.sv
// Time-of-day watch with a button-driven set mode and 12 h / 24 h display mapping.
module watch_gen2
  import watch_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       select,
  input  logic       mode_12h,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       pm,
  output logic [1:0] edit_field,
  output logic       day_carry
);

  localparam logic [6:0] MS_MAX = 7'(TICK_HZ - 1);

  state_e     state_q, state_d;
  logic [6:0] msec_q, msec_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       day_carry_q, rollover;
  logic       tick, clr;
  logic       up, dn, lf, rt;

  assign {up, dn, lf, rt} = btn;

  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_RUN),
    .clr (clr),
    .tick(tick)
  );

  always_comb begin
    state_d  = state_q;
    msec_d   = msec_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    clr      = 1'b0;
    rollover = 1'b0;
    if (state_q == ST_RUN) begin
      if (select) begin
        state_d = ST_SET_SEC;
        msec_d  = '0;
        clr     = 1'b1;
      end else if (tick) begin
        if (msec_q >= MS_MAX) begin
          msec_d = '0;
          if (sec_q >= SEC_LIM - 6'd1) begin
            sec_d = '0;
            if (min_q >= MIN_LIM - 6'd1) begin
              min_d = '0;
              if ({1'b0, hour_q} >= HOUR_LIM - 6'd1) begin
                hour_d   = '0;
                rollover = 1'b1;
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          msec_d = msec_q + 7'd1;
        end
      end
    end else if (!select) begin
      // Leaving set mode wins over any button arriving in the same cycle.
      state_d = ST_RUN;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_SET_SEC:  sec_d  = step_field(sec_q, SEC_LIM, up, dn);
        ST_SET_MIN:  min_d  = step_field(min_q, MIN_LIM, up, dn);
        ST_SET_HOUR: hour_d = 5'(step_field({1'b0, hour_q}, HOUR_LIM, up, dn));
        default:     ;
      endcase
      if (lf && !rt) begin
        unique case (state_q)
          ST_SET_SEC: state_d = ST_SET_MIN;
          ST_SET_MIN: state_d = ST_SET_HOUR;
          default:    state_d = ST_SET_SEC;
        endcase
      end else if (rt && !lf) begin
        unique case (state_q)
          ST_SET_SEC:  state_d = ST_SET_HOUR;
          ST_SET_HOUR: state_d = ST_SET_MIN;
          default:     state_d = ST_SET_SEC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      msec_q      <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= 5'(INIT_HOUR);
      day_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      msec_q      <= msec_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_carry_q <= rollover;
    end
  end

  always_comb begin
    hour = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0) begin
        hour = 5'd12;
      end else if (hour_q > 5'd12) begin
        hour = hour_q - 5'd12;
      end
    end
  end

  assign pm         = mode_12h && (hour_q >= 5'd12);
  assign msec       = msec_q;
  assign sec        = sec_q;
  assign min        = min_q;
  assign edit_field = state_q;
  assign day_carry  = day_carry_q;

endmodule

// File: tb/tb_watch_gen2.sv
// Directed bench: two watches (start hours 23 and 12) share all inputs.
module tb_watch_gen2;

  localparam logic [3:0] UP = 4'b1000;
  localparam logic [3:0] DN = 4'b0100;
  localparam logic [3:0] LF = 4'b0010;
  localparam logic [3:0] RT = 4'b0001;

  logic       clk, rst, select, mode_12h;
  logic [3:0] btn;
  logic [6:0] a_msec, b_msec;
  logic [5:0] a_sec, a_min, b_sec, b_min;
  logic [4:0] a_hour, b_hour;
  logic       a_pm, b_pm, a_dc, b_dc;
  logic [1:0] a_ef, b_ef;

  int n_cmp = 0;
  int n_fail = 0;

  watch_gen2 #(.CLK_HZ(1000), .TICK_HZ(100), .INIT_HOUR(23)) dut_a (
    .clk(clk), .rst(rst), .btn(btn), .select(select), .mode_12h(mode_12h),
    .msec(a_msec), .sec(a_sec), .min(a_min), .hour(a_hour), .pm(a_pm),
    .edit_field(a_ef), .day_carry(a_dc)
  );

  watch_gen2 #(.CLK_HZ(1000), .TICK_HZ(100), .INIT_HOUR(12)) dut_b (
    .clk(clk), .rst(rst), .btn(btn), .select(select), .mode_12h(mode_12h),
    .msec(b_msec), .sec(b_sec), .min(b_min), .hour(b_hour), .pm(b_pm),
    .edit_field(b_ef), .day_carry(b_dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       sel;
    logic [1:0] ef;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic press(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      btn = b;
      step();
      btn = '0;
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 1'b1, 2'd1, 6'd0,  6'd0,  5'd23};
    tbl[1]  = '{DN,      1'b1, 2'd1, 6'd59, 6'd0,  5'd23};
    tbl[2]  = '{LF,      1'b1, 2'd2, 6'd59, 6'd0,  5'd23};
    tbl[3]  = '{DN,      1'b1, 2'd2, 6'd59, 6'd59, 5'd23};
    tbl[4]  = '{UP | DN, 1'b1, 2'd2, 6'd59, 6'd59, 5'd23};
    tbl[5]  = '{LF,      1'b1, 2'd3, 6'd59, 6'd59, 5'd23};
    tbl[6]  = '{UP,      1'b1, 2'd3, 6'd59, 6'd59, 5'd0};
    tbl[7]  = '{DN,      1'b1, 2'd3, 6'd59, 6'd59, 5'd23};
    tbl[8]  = '{LF,      1'b1, 2'd1, 6'd59, 6'd59, 5'd23};
    tbl[9]  = '{RT,      1'b1, 2'd3, 6'd59, 6'd59, 5'd23};
    tbl[10] = '{RT,      1'b1, 2'd2, 6'd59, 6'd59, 5'd23};
    tbl[11] = '{LF | RT, 1'b1, 2'd2, 6'd59, 6'd59, 5'd23};
    tbl[12] = '{UP | RT, 1'b1, 2'd1, 6'd59, 6'd0,  5'd23};
    tbl[13] = '{RT,      1'b1, 2'd3, 6'd59, 6'd0,  5'd23};
    tbl[14] = '{RT,      1'b1, 2'd2, 6'd59, 6'd0,  5'd23};
    tbl[15] = '{DN,      1'b1, 2'd2, 6'd59, 6'd59, 5'd23};
    tbl[16] = '{LF,      1'b0, 2'd0, 6'd59, 6'd59, 5'd23};

    rst = 1'b0; btn = '0; select = 1'b0; mode_12h = 1'b0;
    #22;
    check("rst_a_msec", a_msec, 0);
    check("rst_a_sec", a_sec, 0);
    check("rst_a_min", a_min, 0);
    check("rst_a_hour", a_hour, 23);
    check("rst_b_hour", b_hour, 12);
    check("rst_a_ef", a_ef, 0);
    check("rst_a_dc", a_dc, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      btn = tbl[i].btn;
      select = tbl[i].sel;
      step();
      btn = '0;
      check($sformatf("vec%0d_ef", i), a_ef, tbl[i].ef);
      check($sformatf("vec%0d_sec", i), a_sec, tbl[i].s);
      check($sformatf("vec%0d_min", i), a_min, tbl[i].m);
      check($sformatf("vec%0d_hour", i), a_hour, tbl[i].h);
      check($sformatf("vec%0d_msec", i), a_msec, 0);
    end

    // Running; buttons must be ignored. Divider restarted on the last table edge.
    press(UP | LF, 1);
    steps(988);
    check("run_msec_98", a_msec, 98);
    step();
    check("run_msec_99", a_msec, 99);
    check("run_ef", a_ef, 0);
    check("run_hms", {a_hour, a_min, a_sec}, {5'd23, 6'd59, 6'd59});
    steps(9);
    check("pre_roll_msec", a_msec, 99);
    check("pre_roll_dc", a_dc, 0);
    step();
    check("roll_hms", {a_hour, a_min, a_sec}, 0);
    check("roll_msec", a_msec, 0);
    check("roll_dc", a_dc, 1);
    check("roll_b_hms", {b_hour, b_min, b_sec}, {5'd13, 6'd0, 6'd0});
    check("roll_b_dc", b_dc, 0);
    step();
    check("roll_dc_drop", a_dc, 0);

    mode_12h = 1'b1;
    #1;
    check("h12_0_hour", a_hour, 12);
    check("h12_0_pm", a_pm, 0);
    check("h12_b13_hour", b_hour, 1);
    steps(25);
    check("msec_before_set", a_msec, 2);
    select = 1'b1;
    step();
    check("set_ef", a_ef, 1);
    check("set_msec_clr", a_msec, 0);
    steps(15);
    check("set_frozen", a_msec, 0);
    press(LF, 2);
    press(UP, 12);
    check("h12_12_hour", a_hour, 12);
    check("h12_12_pm", a_pm, 1);
    press(UP, 1);
    check("h12_13_hour", a_hour, 1);
    check("h12_13_pm", a_pm, 1);
    mode_12h = 1'b0;
    #1;
    check("h24_13_hour", a_hour, 13);
    check("h24_13_pm", a_pm, 0);

    press(DN, 14);
    check("hour_23", a_hour, 23);
    press(LF, 1);
    check("back_sec_ef", a_ef, 1);
    press(LF, 2);
    press(UP, 1);
    check("llu_ef", a_ef, 3);
    check("llu_hour", a_hour, 0);
    press(LF, 1);
    check("wrap_ef", a_ef, 1);

    press(LF, 1);
    press(UP, 30);
    check("min_30", a_min, 30);
    press(UP | DN, 1);
    check("updn_min", a_min, 30);
    check("updn_ef", a_ef, 2);
    btn = LF; select = 1'b0;
    step();
    btn = '0;
    check("exit_ef", a_ef, 0);
    check("exit_min", a_min, 30);
    check("exit_sec", a_sec, 0);

    select = 1'b1;
    step();
    press(UP, 30);
    press(LF, 1);
    press(DN, 10);
    press(LF, 1);
    press(DN, 3);
    check("edit_b_hms", {b_hour, b_min, b_sec}, {5'd10, 6'd20, 6'd30});
    check("edit_b_ef", b_ef, 3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_b_hms", {b_hour, b_min, b_sec}, {5'd12, 6'd0, 6'd0});
    check("arst_b_msec", b_msec, 0);
    check("arst_b_ef", b_ef, 0);
    check("arst_a_hour", a_hour, 23);
    check("arst_dc", a_dc, 0);
    select = 1'b0;
    #3;
    rst = 1'b1;
    step();
    check("post_rst_ef", b_ef, 0);
    check("post_rst_hour", b_hour, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
